// File: rtl/fp_pkg.sv
// Shared types for the floating-point alignment pipeline.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // hidden + fraction + guard + round + sticky
    function automatic int sig_width(input int man_w);
        return man_w + 4;
    endfunction

    localparam int SIG_W_DEF = sig_width(MAN_W_DEF);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } op_class_e;

    typedef struct packed {
        logic      sign;
        logic      hidden;
        op_class_e cls;
    } op_info_t;

    function automatic op_class_e classify(
        input logic exp_zero,
        input logic exp_ones,
        input logic frac_zero,
        input logic special
    );
        if (exp_zero)
            return frac_zero ? CLS_ZERO : CLS_SUB;
        if (special && exp_ones)
            return frac_zero ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_sticky_shift.sv
// Right shift of a significand with saturation; shifted-out bits fold
// into the LSB as a sticky bit.
module fp_sticky_shift #(
    parameter int SIG_W = 27,
    parameter int SH_W  = 8
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [SH_W-1:0]  shamt,
    output logic [SIG_W-1:0] res
);

    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] lost_mask;
    logic             sat;

    always_comb begin
        sat       = 32'(shamt) >= SIG_W;
        shifted   = sig >> shamt;
        lost_mask = ~({SIG_W{1'b1}} << shamt);
        if (sat)
            res = {{(SIG_W-1){1'b0}}, |sig};
        else
            res = {shifted[SIG_W-1:1], shifted[0] | (|(sig & lost_mask))};
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage FP add/sub operand alignment: S1 classify/compare/swap,
// S2 shift/sticky. Define FP_ALIGN_SPECIAL_EN for inf/NaN handling.
module fp_align_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W+3:0]   big_sig,
    output logic [MAN_W+3:0]   small_sig,
    output logic [EXP_W-1:0]   res_exp,
    output logic               res_sign,
    output logic               eff_sub,
    output logic               swapped,
    output logic               out_nan,
    output logic               out_inf
);

    localparam int SIG_W = sig_width(MAN_W);
    localparam int KEY_W = EXP_W + 1 + MAN_W;
`ifdef FP_ALIGN_SPECIAL_EN
    localparam logic SPECIAL = 1'b1;
`else
    localparam logic SPECIAL = 1'b0;
`endif

    logic [EXP_W-1:0] ea_raw, eb_raw, ea, eb, big_e, small_e;
    logic [MAN_W-1:0] fa, fb;
    op_info_t         op_a, op_b;
    logic [KEY_W-1:0] key_a, key_b;
    logic [SIG_W-1:0] sig_a, sig_b;
    logic             swap, tie, both_zero, esub, nan, inf, sign, big_h;

    always_comb begin
        ea_raw      = in_a[MAN_W +: EXP_W];
        eb_raw      = in_b[MAN_W +: EXP_W];
        fa          = in_a[MAN_W-1:0];
        fb          = in_b[MAN_W-1:0];
        op_a.sign   = in_a[EXP_W+MAN_W];
        op_b.sign   = in_b[EXP_W+MAN_W] ^ in_sub;
        op_a.hidden = |ea_raw;
        op_b.hidden = |eb_raw;
        op_a.cls    = classify(~|ea_raw, &ea_raw, ~|fa, SPECIAL);
        op_b.cls    = classify(~|eb_raw, &eb_raw, ~|fb, SPECIAL);
        // subnormals share the exponent of the smallest normal
        ea          = op_a.hidden ? ea_raw : EXP_W'(1);
        eb          = op_b.hidden ? eb_raw : EXP_W'(1);
        key_a       = {ea, op_a.hidden, fa};
        key_b       = {eb, op_b.hidden, fb};
        swap        = key_b > key_a;
        tie         = key_a == key_b;
        esub        = op_a.sign ^ op_b.sign;
        both_zero   = (op_a.cls == CLS_ZERO) && (op_b.cls == CLS_ZERO);
        nan         = (op_a.cls == CLS_NAN) || (op_b.cls == CLS_NAN) ||
                      ((op_a.cls == CLS_INF) && (op_b.cls == CLS_INF) && esub);
        inf         = ((op_a.cls == CLS_INF) || (op_b.cls == CLS_INF)) && !nan;
        sig_a       = {op_a.hidden, fa, 3'b000};
        sig_b       = {op_b.hidden, fb, 3'b000};
        big_e       = swap ? eb : ea;
        small_e     = swap ? ea : eb;
        big_h       = swap ? op_b.hidden : op_a.hidden;
        if (both_zero)
            sign = op_a.sign & op_b.sign;
        else if (tie && esub)
            sign = 1'b0;
        else
            sign = swap ? op_b.sign : op_a.sign;
    end

    logic             s1_valid;
    logic [SIG_W-1:0] s1_big, s1_small, shifted;
    logic [EXP_W-1:0] s1_shamt, s1_exp;
    logic             s1_sign, s1_esub, s1_swap, s1_nan, s1_inf;
    logic             s1_adv, s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_big   <= '0;
            s1_small <= '0;
            s1_shamt <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_esub  <= 1'b0;
            s1_swap  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_big   <= (nan || inf) ? '0 : (swap ? sig_b : sig_a);
                s1_small <= (nan || inf) ? '0 : (swap ? sig_a : sig_b);
                s1_shamt <= big_e - small_e;
                s1_exp   <= (nan || inf) ? '1 : (big_h ? big_e : '0);
                s1_sign  <= sign;
                s1_esub  <= esub;
                s1_swap  <= swap;
                s1_nan   <= nan;
                s1_inf   <= inf;
            end
        end
    end

    fp_sticky_shift #(
        .SIG_W(SIG_W),
        .SH_W (EXP_W)
    ) u_shift (
        .sig  (s1_small),
        .shamt(s1_shamt),
        .res  (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            big_sig   <= '0;
            small_sig <= '0;
            res_exp   <= '0;
            res_sign  <= 1'b0;
            eff_sub   <= 1'b0;
            swapped   <= 1'b0;
            out_nan   <= 1'b0;
            out_inf   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                big_sig   <= s1_big;
                small_sig <= shifted;
                res_exp   <= s1_exp;
                res_sign  <= s1_sign;
                eff_sub   <= s1_esub;
                swapped   <= s1_swap;
                out_nan   <= s1_nan;
                out_inf   <= s1_inf;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe (single precision defaults),
// directed cases plus randomized traffic against a value-level model.
module tb_fp_align_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [26:0] big_sig, small_sig;
    logic [7:0]  res_exp;
    logic        res_sign, eff_sub, swapped, out_nan, out_inf;

    fp_align_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .big_sig(big_sig), .small_sig(small_sig),
        .res_exp(res_exp), .res_sign(res_sign),
        .eff_sub(eff_sub), .swapped(swapped),
        .out_nan(out_nan), .out_inf(out_inf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] big_sig;
        logic [26:0] small_sig;
        logic [7:0]  res_exp;
        logic        res_sign, eff_sub, swapped, nan, inf;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] pa[$], pb[$];
    logic        ps[$];
    int          n_cmp = 0, n_bad = 0;
    logic        accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Magnitude of an operand is sig * 2^exp; ordering key exp*2^24+sig
    // is exact because a normal significand always lies in [2^23, 2^24).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t   r;
        int     ea, eb, ra, rb, be, se, d;
        longint ma, mb, va, vb, bm, sm, lost;
        logic   sa, sb, sw, bs, na, nb, ia, ib;
        sa = a[31];
        sb = b[31] ^ sub;
        ra = int'(a[30:23]);
        rb = int'(b[30:23]);
        ma = longint'(a[22:0]);
        mb = longint'(b[22:0]);
        if (ra != 0) ma += 2**23;
        if (rb != 0) mb += 2**23;
        ea = (ra == 0) ? 1 : ra;
        eb = (rb == 0) ? 1 : rb;
        va = longint'(ea) * 2**24 + ma;
        vb = longint'(eb) * 2**24 + mb;
        sw = vb > va;
        be = sw ? eb : ea;
        se = sw ? ea : eb;
        bm = sw ? mb : ma;
        sm = (sw ? ma : mb) * 8;
        bs = sw ? sb : sa;
        r.swapped = sw;
        r.eff_sub = sa ^ sb;
        r.res_exp = (bm >= 2**23) ? be[7:0] : 8'd0;
        r.big_sig = 27'(bm * 8);
        d = be - se;
        if (d >= 27) begin
            r.small_sig = (sm != 0) ? 27'd1 : 27'd0;
        end else begin
            lost = sm % (longint'(1) << d);
            r.small_sig = 27'(sm >> d) | 27'(lost != 0);
        end
        if (ma == 0 && mb == 0) r.res_sign = sa & sb;
        else if (va == vb && sa != sb) r.res_sign = 1'b0;
        else r.res_sign = bs;
        r.nan = 1'b0;
        r.inf = 1'b0;
`ifdef FP_ALIGN_SPECIAL_EN
        na = (ra == 255) && (a[22:0] != 0);
        nb = (rb == 255) && (b[22:0] != 0);
        ia = (ra == 255) && (a[22:0] == 0);
        ib = (rb == 255) && (b[22:0] == 0);
        r.nan = na || nb || (ia && ib && (sa != sb));
        r.inf = (ia || ib) && !r.nan;
        if (r.nan || r.inf) begin
            r.big_sig   = 27'd0;
            r.small_sig = 27'd0;
            r.res_exp   = 8'hFF;
        end
`else
        na = 1'b0; nb = 1'b0; ia = 1'b0; ib = 1'b0;
`endif
        return r;
    endfunction

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_cmp++;
            assert (sbq.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_unexpected_output: observed output expected none");
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_big_sig", big_sig, e.big_sig);
                chk("sb_small_sig", small_sig, e.small_sig);
                chk("sb_res_exp", res_exp, e.res_exp);
                chk("sb_res_sign", res_sign, e.res_sign);
                chk("sb_eff_sub", eff_sub, e.eff_sub);
                chk("sb_swapped", swapped, e.swapped);
                chk("sb_nan", out_nan, e.nan);
                chk("sb_inf", out_inf, e.inf);
            end
        end
        if (accepted) sbq.push_back(model(in_a, in_b, in_sub));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle();
        if (pa.size() != 0) begin
            in_valid = 1'b1;
            in_a = pa[0];
            in_b = pb[0];
            in_sub = ps[0];
        end else begin
            in_valid = 1'b0;
        end
        cycle();
        if (accepted) begin
            void'(pa.pop_front());
            void'(pb.pop_front());
            void'(ps.pop_front());
        end
    endtask

    // Offer one pair; returns post-edge with the result due on the outputs.
    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic sub);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        cycle();
        in_valid = 1'b0;
        chk("lat_early_valid", out_valid, 0);
        cycle();
        chk("lat_valid", out_valid, 1);
    endtask

    function automatic logic [31:0] rnd_op(input int base);
        int          e;
        logic [31:0] r;
        case ($urandom % 8)
            0: e = 0;
            1: e = 255;
            default: e = base + int'($urandom_range(0, 60)) - 30;
        endcase
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        r = {1'($urandom), 8'(e), 23'($urandom)};
        if ($urandom % 10 == 0) r[22:0] = 23'd0;
        return r;
    endfunction

    task automatic push_rand();
        int          base;
        logic [31:0] a, b;
        base = int'($urandom_range(1, 254));
        a = rnd_op(base);
        b = rnd_op(base);
        if ($urandom % 8 == 0) b = {1'($urandom), a[30:0]};
        pa.push_back(a);
        pb.push_back(b);
        ps.push_back(1'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (pa.size() == 0 && sbq.size() == 0) break;
            drive_cycle();
        end
        chk("drain_pending", pa.size(), 0);
        chk("drain_outstanding", sbq.size(), 0);
    endtask

    logic [26:0] snap_big, snap_small;
    logic [7:0]  snap_exp;
    int          acc;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_big_sig", big_sig, 0);
        chk("rst_small_sig", small_sig, 0);
        chk("rst_res_exp", res_exp, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        directed(32'h3F800000, 32'h3FC00000, 1'b0);
        chk("d1_swapped", swapped, 1);
        chk("d1_res_exp", res_exp, 8'h7F);
        chk("d1_big_sig", big_sig, 27'h6000000);
        chk("d1_small_sig", small_sig, 27'h4000000);
        chk("d1_eff_sub", eff_sub, 0);
        cycle();

        directed(32'h4F000000, 32'h3F800001, 1'b0);
        chk("d2_small_sig", small_sig, 27'h0000001);
        chk("d2_res_exp", res_exp, 8'h9E);
        chk("d2_swapped", swapped, 0);
        cycle();

        directed(32'h00000001, 32'h00800000, 1'b0);
        chk("d3_res_exp", res_exp, 8'h01);
        chk("d3_big_sig", big_sig, 27'h4000000);
        chk("d3_small_sig", small_sig, 27'h0000008);
        chk("d3_swapped", swapped, 1);
        cycle();

        directed(32'h7F800000, 32'h7F800000, 1'b1);
`ifdef FP_ALIGN_SPECIAL_EN
        chk("d4_nan", out_nan, 1);
        chk("d4_inf", out_inf, 0);
        chk("d4_res_exp", res_exp, 8'hFF);
`else
        chk("d4_nan", out_nan, 0);
        chk("d4_inf", out_inf, 0);
        chk("d4_eff_sub", eff_sub, 1);
`endif
        cycle();

        directed(32'h80000000, 32'h00000000, 1'b1);
        chk("d5_zero_sign", res_sign, 1);
        cycle();

        out_ready = 1'b0;
        acc = 0;
        repeat (4) push_rand();
        for (int i = 0; i < 5; i++) begin
            drive_cycle();
            if (accepted) acc++;
            if (i == 1) begin
                snap_big = big_sig;
                snap_small = small_sig;
                snap_exp = res_exp;
            end
            if (i >= 2) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_big_sig", big_sig, snap_big);
                chk("stall_small_sig", small_sig, snap_small);
                chk("stall_res_exp", res_exp, snap_exp);
            end
        end
        chk("stall_accepted", acc, 2);
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        repeat (2) push_rand();
        drive_cycle();
        drive_cycle();
        chk("prerst_out_valid", out_valid, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_big_sig", big_sig, 0);
        chk("mrst_small_sig", small_sig, 0);
        chk("mrst_res_exp", res_exp, 0);
        chk("mrst_flags", {res_sign, eff_sub, swapped, out_nan, out_inf}, 0);
        sbq.delete();
        pa.delete();
        pb.delete();
        ps.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mrst_in_ready", in_ready, 1);
        directed(32'h40400000, 32'h3F800000, 1'b1);
        chk("mrst_res_exp_after", res_exp, 8'h80);
        chk("mrst_small_after", small_sig, 27'h2000000);
        cycle();
        chk("mrst_no_extra", out_valid, 0);

        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom % 4) != 0;
            if (pa.size() == 0 && ($urandom % 3) != 0) push_rand();
            drive_cycle();
        end
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
